// File: rtl/tug_game_ctrl.sv
// Tug of War game sequencer: reset display, countdown, play, win flash, done.
// Define FALSE_START_EN to treat presses during the countdown as fouls.
module tug_game_ctrl #(
  parameter int RST_TICKS   = 4,
  parameter int START_TICKS = 3,
  parameter int WIN_FLASHES = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       new_game,
  output logic [1:0] leds_ctrl,
  output logic [6:0] score,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    SHOW_RESET,
    COUNTDOWN,
    PLAY,
    WIN,
    DONE
  } state_t;

  localparam logic [3:0] RST_LAST   = 4'(RST_TICKS - 1);
  localparam logic [3:0] START_LAST = 4'(START_TICKS - 1);
  localparam logic [3:0] WIN_LAST   = 4'(WIN_FLASHES - 1);

  localparam logic [1:0] LEDS_OFF   = 2'd0;
  localparam logic [1:0] LEDS_ON    = 2'd1;
  localparam logic [1:0] LEDS_RESET = 2'd2;
  localparam logic [1:0] LEDS_SCORE = 2'd3;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b10;
  localparam logic [1:0] WIN_RIGHT = 2'b01;

  localparam logic [2:0] POS_CENTRE = 3'd3;
  localparam logic [2:0] POS_LEFT   = 3'd6;
  localparam logic [2:0] POS_RIGHT  = 3'd0;

  state_t     state_reg;
  logic [3:0] tick_cnt_reg;
  logic [2:0] pos_reg;
  logic       btn_l_q;
  logic       btn_r_q;
  logic       press_l;
  logic       press_r;

  assign press_l = btn_l & ~btn_l_q;
  assign press_r = btn_r & ~btn_r_q;

  function automatic logic [6:0] pos_onehot(input logic [2:0] p);
    pos_onehot = 7'd1 << p;
  endfunction

  // score is kept as its own register so every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= SHOW_RESET;
      tick_cnt_reg <= 4'd0;
      pos_reg      <= POS_CENTRE;
      btn_l_q      <= 1'b0;
      btn_r_q      <= 1'b0;
      leds_ctrl    <= LEDS_RESET;
      score        <= pos_onehot(POS_CENTRE);
      winner       <= WIN_NONE;
    end else begin
      btn_l_q <= btn_l;
      btn_r_q <= btn_r;
      case (state_reg)
        SHOW_RESET: begin
          if (tick) begin
            if (tick_cnt_reg == RST_LAST) begin
              state_reg    <= COUNTDOWN;
              tick_cnt_reg <= 4'd0;
              pos_reg      <= POS_CENTRE;
              score        <= pos_onehot(POS_CENTRE);
              winner       <= WIN_NONE;
              leds_ctrl    <= LEDS_OFF;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 4'd1;
            end
          end
        end

        COUNTDOWN: begin
`ifdef FALSE_START_EN
          // A foul outranks a tick arriving in the same cycle.
          if (press_l && press_r) begin
            tick_cnt_reg <= 4'd0;
            pos_reg      <= POS_CENTRE;
            score        <= pos_onehot(POS_CENTRE);
          end else if (press_l) begin
            state_reg    <= WIN;
            tick_cnt_reg <= 4'd0;
            pos_reg      <= POS_RIGHT;
            score        <= pos_onehot(POS_RIGHT);
            winner       <= WIN_RIGHT;
            leds_ctrl    <= LEDS_ON;
          end else if (press_r) begin
            state_reg    <= WIN;
            tick_cnt_reg <= 4'd0;
            pos_reg      <= POS_LEFT;
            score        <= pos_onehot(POS_LEFT);
            winner       <= WIN_LEFT;
            leds_ctrl    <= LEDS_ON;
          end else
`endif
          if (tick) begin
            if (tick_cnt_reg == START_LAST) begin
              state_reg    <= PLAY;
              tick_cnt_reg <= 4'd0;
              leds_ctrl    <= LEDS_SCORE;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 4'd1;
            end
          end
        end

        PLAY: begin
          // pos stays within 1..5 here, so one step can never leave 0..6.
          if (press_l && !press_r) begin
            pos_reg <= pos_reg + 3'd1;
            score   <= pos_onehot(pos_reg + 3'd1);
            if (pos_reg == POS_LEFT - 3'd1) begin
              state_reg    <= WIN;
              tick_cnt_reg <= 4'd0;
              winner       <= WIN_LEFT;
              leds_ctrl    <= LEDS_ON;
            end
          end else if (press_r && !press_l) begin
            pos_reg <= pos_reg - 3'd1;
            score   <= pos_onehot(pos_reg - 3'd1);
            if (pos_reg == POS_RIGHT + 3'd1) begin
              state_reg    <= WIN;
              tick_cnt_reg <= 4'd0;
              winner       <= WIN_RIGHT;
              leds_ctrl    <= LEDS_ON;
            end
          end
        end

        WIN: begin
          if (tick) begin
            if (tick_cnt_reg == WIN_LAST) begin
              state_reg    <= DONE;
              tick_cnt_reg <= 4'd0;
              leds_ctrl    <= LEDS_SCORE;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 4'd1;
              leds_ctrl    <= (leds_ctrl == LEDS_ON) ? LEDS_SCORE : LEDS_ON;
            end
          end
        end

        DONE: begin
          if (new_game) begin
            state_reg    <= SHOW_RESET;
            tick_cnt_reg <= 4'd0;
            winner       <= WIN_NONE;
            leds_ctrl    <= LEDS_RESET;
          end
        end

        default: begin
          state_reg    <= SHOW_RESET;
          tick_cnt_reg <= 4'd0;
          leds_ctrl    <= LEDS_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tug_game_ctrl.sv
// Scoreboarded bench for tug_game_ctrl: directed game scenarios followed by random play,
// checked cycle by cycle against a rule-level model of the game.
module tb_tug_game_ctrl;

  localparam int RST_TICKS   = 4;
  localparam int START_TICKS = 3;
  localparam int WIN_FLASHES = 6;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       btn_l;
  logic       btn_r;
  logic       new_game;
  logic [1:0] leds_ctrl;
  logic [6:0] score;
  logic [1:0] winner;

  tug_game_ctrl #(
    .RST_TICKS  (RST_TICKS),
    .START_TICKS(START_TICKS),
    .WIN_FLASHES(WIN_FLASHES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .btn_l    (btn_l),
    .btn_r    (btn_r),
    .new_game (new_game),
    .leds_ctrl(leds_ctrl),
    .score    (score),
    .winner   (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] leds;
    logic [6:0] score;
    logic [1:0] win;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_no   = 0;

  // Reference model: game phase, ticks seen in that phase, rope position,
  // winner as 0 none / 1 left / 2 right, last button levels.
  localparam int PH_RESET = 0, PH_COUNT = 1, PH_PLAY = 2, PH_WIN = 3, PH_DONE = 4;
  int m_phase, m_ticks, m_pos, m_win;
  bit m_bl, m_br;

  function automatic logic [1:0] m_leds();
    case (m_phase)
      PH_RESET: return 2'd2;
      PH_COUNT: return 2'd0;
      PH_WIN:   return (m_ticks % 2 == 0) ? 2'd1 : 2'd3;
      default:  return 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] m_win_bits();
    if (m_win == 1) return 2'b10;
    if (m_win == 2) return 2'b01;
    return 2'b00;
  endfunction

  task automatic m_declare(input int who);
    m_win   = who;
    m_pos   = (who == 1) ? 6 : 0;
    m_phase = PH_WIN;
    m_ticks = 0;
  endtask

  task automatic m_step(input bit rst, input bit tk, input bit bl, input bit br, input bit ng);
    bit pl, pr;
    if (!rst) begin
      m_phase = PH_RESET; m_ticks = 0; m_pos = 3; m_win = 0; m_bl = 0; m_br = 0;
      return;
    end
    pl = bl && !m_bl;
    pr = br && !m_br;
    m_bl = bl;
    m_br = br;
    case (m_phase)
      PH_RESET: if (tk) begin
        m_ticks++;
        if (m_ticks == RST_TICKS) begin m_phase = PH_COUNT; m_ticks = 0; m_pos = 3; m_win = 0; end
      end
      PH_COUNT: begin
`ifdef FALSE_START_EN
        if (pl && pr) begin m_ticks = 0; m_pos = 3; end
        else if (pl) m_declare(2);
        else if (pr) m_declare(1);
        else
`endif
        if (tk) begin
          m_ticks++;
          if (m_ticks == START_TICKS) begin m_phase = PH_PLAY; m_ticks = 0; end
        end
      end
      PH_PLAY: if (pl != pr) begin
        m_pos += pl ? 1 : -1;
        if (m_pos == 6) m_declare(1);
        else if (m_pos == 0) m_declare(2);
      end
      PH_WIN: if (tk) begin
        m_ticks++;
        if (m_ticks == WIN_FLASHES) begin m_phase = PH_DONE; m_ticks = 0; end
      end
      default: if (ng) begin m_phase = PH_RESET; m_ticks = 0; m_win = 0; end
    endcase
  endtask

  // Stimulus: inputs change on the falling edge, the expected post-edge outputs are queued.
  bit rst_v = 0, bl_v = 0, br_v = 0;

  task automatic cyc(input bit tk, input bit ng);
    exp_t e;
    @(negedge clk);
    rst_n    = rst_v;
    btn_l    = bl_v;
    btn_r    = br_v;
    tick     = tk;
    new_game = ng;
    m_step(rst_v, tk, bl_v, br_v, ng);
    cyc_no++;
    e.leds  = m_leds();
    e.score = 7'd1 << m_pos;
    e.win   = m_win_bits();
    e.cyc   = cyc_no;
    exp_q.push_back(e);
  endtask

  task automatic run_ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) cyc((i % gap) == gap - 1, 1'b0);
  endtask

  task automatic press_l_once();
    bl_v = 1; cyc(1'b0, 1'b0);
    bl_v = 0; cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
  endtask

  task automatic press_r_once();
    br_v = 1; cyc(1'b0, 1'b0);
    br_v = 0; cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
  endtask

  // Monitor: the outputs are valid every cycle, so one expectation is popped per edge.
  exp_t       prev_e;
  bit         have_prev = 0;
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks += 3;
      if (leds_ctrl !== e.leds) begin
        n_fail++;
        $display("FAIL leds_ctrl cyc %0d got %0d expected %0d", e.cyc, leds_ctrl, e.leds);
      end
      if (score !== e.score) begin
        n_fail++;
        $display("FAIL score cyc %0d got %b expected %b", e.cyc, score, e.score);
      end
      if (winner !== e.win) begin
        n_fail++;
        $display("FAIL winner cyc %0d got %b expected %b", e.cyc, winner, e.win);
      end
      if (!have_prev || e.leds != prev_e.leds || e.score != prev_e.score || e.win != prev_e.win)
        $display("cyc %0d: leds_ctrl=%0d score=%b winner=%b", e.cyc, e.leds, e.score, e.win);
      prev_e    = e;
      have_prev = 1;
    end
  end

  initial begin
    rst_n = 0; tick = 0; btn_l = 0; btn_r = 0; new_game = 0;
    m_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset, then reset pattern, countdown and into play.
    rst_v = 0; run_ticks(3, 2);
    rst_v = 1; run_ticks(24, 3);

    // Three left edges win the game, then the flash runs out into DONE.
    press_l_once(); press_l_once(); press_l_once();
    run_ticks(24, 3);

    // Start a fresh game.
    cyc(1'b0, 1'b1);
    run_ticks(24, 3);

    // new_game mid-play, simultaneous edges, and a long held button.
    cyc(1'b0, 1'b1);
    bl_v = 1; br_v = 1; cyc(1'b0, 1'b0);
    bl_v = 0; br_v = 0; cyc(1'b0, 1'b0);
    br_v = 1; run_ticks(50, 4);
    br_v = 0; cyc(1'b0, 1'b0);
    press_r_once(); press_r_once();

    // Reset in the middle of the win flash with the left button held through it.
    run_ticks(5, 2);
    bl_v = 1; rst_v = 0; cyc(1'b0, 1'b0);
    rst_v = 1; run_ticks(6, 2);
    bl_v = 0; run_ticks(24, 3);

    // Countdown presses: fouls with FALSE_START_EN, ignored otherwise.
    cyc(1'b0, 1'b0);
    rst_v = 0; cyc(1'b0, 1'b0);
    rst_v = 1; run_ticks(12, 3);
    press_r_once();
    run_ticks(30, 3);

    // Random play.
    for (int i = 0; i < 4000; i++) begin
      rst_v = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 3) == 0) bl_v = ~bl_v;
      if ($urandom_range(0, 3) == 0) br_v = ~br_v;
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 14) == 0);
    end

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tug_game_ctrl.md
# tug_game_ctrl

Game-control sequencer for the Tug of War design. It turns the two player buttons and a slow tick into the 2-bit LED mode select and the 7-bit score pattern consumed by the downstream LED multiplexer. It also owns the rope position, the win detection and the reset/countdown/win-flash sequencing.

## Interface
Parameters:
- RST_TICKS, default 4: ticks spent showing the reset pattern (1..15).
- START_TICKS, default 3: countdown ticks with LEDs off before play (1..15).
- WIN_FLASHES, default 6: tick-paced toggles in the win flash (1..15).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle pulse that paces all timed states.
- btn_l  in  1  left player button, level, already synchronized and debounced.
- btn_r  in  1  right player button, level, already synchronized and debounced.
- new_game  in  1  one-cycle pulse; restarts from DONE only.
- leds_ctrl  out  2  LED mode: 0 all off, 1 all on, 2 reset code, 3 show score.
- score  out  7  one-hot rope position; bit 6 is the left end, bit 3 is centre.
- winner  out  2  00 none, 10 left, 01 right.

## Operation
- Press detection: press_l = btn_l & ~btn_l_q, where btn_l_q is registered each clock. press_r is formed the same way.
- pos is 3 bits, range 0..6. score = 1 << pos.
- States:
  - SHOW_RESET: leds_ctrl=2. After RST_TICKS ticks, go to COUNTDOWN with pos=3 and winner=00.
  - COUNTDOWN: leds_ctrl=0. Presses are ignored unless FALSE_START_EN is defined. After START_TICKS ticks, go to PLAY.
  - PLAY: leds_ctrl=3.
    - press_l alone: pos+1.
    - press_r alone: pos-1.
    - Both in the same cycle: cancel, no move.
    - When pos reaches 6, set winner=10 and go to WIN. When pos reaches 0, set winner=01 and go to WIN.
  - WIN: pos is frozen. On each tick, leds_ctrl toggles between 1 and 3, starting at 1 on entry. After WIN_FLASHES ticks, go to DONE.
  - DONE: leds_ctrl=3. score and winner hold. new_game goes to SHOW_RESET and clears winner.
- new_game is ignored in every state except DONE.
- Tick counter is 4 bits. It clears on every state change and increments only on tick.
- pos never leaves 0..6. No wrap-around.

## Timing
- All outputs are registered. A press edge in cycle n shows a changed score in cycle n+1.
- A transition triggered by tick in cycle n is visible on the outputs in cycle n+1.
- The winning press in cycle n gives, in cycle n+1: pos at the end, winner set, leds_ctrl=1.
- Reset values: leds_ctrl=2, score=7'b0001000, winner=00, state SHOW_RESET, counters 0, btn_l_q=btn_r_q=0.
- rst_n asserted at any time, including mid-PLAY or mid-WIN, immediately forces the reset values. Operation restarts from SHOW_RESET after release.
- A button held across reset release registers at most one edge, and that edge is ignored in SHOW_RESET.
- tick and press in the same PLAY cycle: the press is processed. Tick has no effect in PLAY.

## Configuration
- FALSE_START_EN defined:
  - A press in COUNTDOWN is a foul. The offending player loses: winner=01 if left pressed, 10 if right pressed. pos moves to the winner's end, and the block goes to WIN.
  - Both players pressing in the same cycle is a double foul: restart COUNTDOWN with the counter cleared and pos=3.
- FALSE_START_EN undefined: presses in COUNTDOWN are ignored.

## Test plan
- Reset release with RST_TICKS=4: leds_ctrl=2 for 4 ticks, then 0 for 3 ticks, then 3 with score=7'b0001000.
- PLAY, three isolated btn_l edges: score steps through 0010000, 0100000, 1000000. On the third edge, winner=10 and leds_ctrl=1 the next cycle. Over 6 ticks leds_ctrl toggles 1/3, then holds at 3.
- PLAY, btn_l and btn_r rising in the same cycle: score stays at 0001000. btn_r held high for 50 cycles: only one step.
- DONE: new_game returns to leds_ctrl=2 with winner=00. new_game pulsed during PLAY: no effect.
- rst_n pulsed low mid-WIN: the next cycle shows leds_ctrl=2, score=0001000, winner=00.
- FALSE_START_EN defined, btn_r edge in COUNTDOWN: winner=10 and score=1000000, then WIN. Undefined: no change.
